regfile_write_arbiter: RTL

// - Round-robin arbiter that shares the register file's single write port between NUM_REQ requesters.
// - Typical requesters: ALU writeback, load return, HI/LO move unit.
// - Sits between the requesters and the register file's WriteRegister/WriteData/WriteEnable inputs.
// - Registered output stage; accepted writes reach the register file one cycle after acceptance.

---
 rtl/regfile_write_arbiter.sv | 92 +++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbiter sharing the register file write port between NUM_REQ requesters.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   ReqValid/ReqAddr/ReqData (in)    per-requester write requests, packed by requester index
//   ReqReady (out)                   one-hot combinational grant
//   WrStall (in)                     register file cannot take a write this cycle
//   WriteEnable/WriteRegister/WriteData (out)  registered write port
// Optional feature macro REGFILE_WRITE_BYPASS_EN adds ReadRegister1/2 inputs and Fwd1/2 Hit/Data
// outputs that forward the pending registered write to readers.
module regfile_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        ReqValid,
    input  logic [NUM_REQ*ADDR_W-1:0] ReqAddr,
    input  logic [NUM_REQ*DATA_W-1:0] ReqData,
    output logic [NUM_REQ-1:0]        ReqReady,
    input  logic                      WrStall,
`ifdef REGFILE_WRITE_BYPASS_EN
    input  logic [ADDR_W-1:0]         ReadRegister1,
    input  logic [ADDR_W-1:0]         ReadRegister2,
    output logic                      Fwd1Hit,
    output logic                      Fwd2Hit,
    output logic [DATA_W-1:0]         Fwd1Data,
    output logic [DATA_W-1:0]         Fwd2Data,
`endif
    output logic                      WriteEnable,
    output logic [ADDR_W-1:0]         WriteRegister,
    output logic [DATA_W-1:0]         WriteData
);
    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]     ptr_q, ptr_d, win, idx;
    logic              found, accept;
    logic [ADDR_W-1:0] sel_addr, addr_q, addr_d;
    logic [DATA_W-1:0] sel_data, data_q, data_d;
    logic              we_q, we_d;

    // Scan pointer+1, pointer+2, ... and take the first valid requester.
    always_comb begin
        found = 1'b0;
        win = ptr_q;
        idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = PW'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && ReqValid[idx]) begin
                found = 1'b1;
                win = idx;
            end
        end
    end

    always_comb begin
        accept   = found & ~WrStall & rst_n;
        ReqReady = accept ? (NUM_REQ'(1) << win) : '0;
        sel_addr = ReqAddr[win*ADDR_W +: ADDR_W];
        sel_data = ReqData[win*DATA_W +: DATA_W];
        // Writes to $zero are accepted but dropped; addr/data keep their last value.
        we_d     = WrStall ? we_q : (accept & (sel_addr != '0));
        addr_d   = (accept & (sel_addr != '0)) ? sel_addr : addr_q;
        data_d   = (accept & (sel_addr != '0)) ? sel_data : data_q;
        ptr_d    = accept ? win : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= PW'(NUM_REQ - 1);
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign WriteEnable   = we_q;
    assign WriteRegister = addr_q;
    assign WriteData     = data_q;

`ifdef REGFILE_WRITE_BYPASS_EN
    assign Fwd1Hit  = we_q & (addr_q == ReadRegister1) & (ReadRegister1 != '0);
    assign Fwd2Hit  = we_q & (addr_q == ReadRegister2) & (ReadRegister2 != '0);
    assign Fwd1Data = Fwd1Hit ? data_q : '0;
    assign Fwd2Data = Fwd2Hit ? data_q : '0;
`endif
endmodule
